// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
//   Shared types and constants for the interval timer controller.
//   - state_e   : controller FSM states
//   - DEF_CNT_W : default counter / compare width
//   - DEF_PRE_W : default prescaler width
//   - OVF_W     : width of the missed-interrupt counter (TIMER_OVF_CNT_EN builds)
// ---------------------------------------------------------------------------
package timer_pkg;

  localparam int DEF_CNT_W = 8;
  localparam int DEF_PRE_W = 4;
  localparam int OVF_W     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } state_e;

endpackage

// File: rtl/interval_timer_ctrl_if.sv
// ---------------------------------------------------------------------------
// interval_timer_ctrl_if
//   Control/status bundle between the register side (master) and the
//   interval timer controller (slave).
//   master -> slave : start, stop, hold, periodic, cmp_val, prescale, irq_ack
//   slave -> master : busy, expired, irq, cnt_out, ovf_cnt (TIMER_OVF_CNT_EN)
//   Optional macro: TIMER_OVF_CNT_EN adds the ovf_cnt status field.
// ---------------------------------------------------------------------------
interface interval_timer_ctrl_if #(
  parameter int CNT_W = timer_pkg::DEF_CNT_W,
  parameter int PRE_W = timer_pkg::DEF_PRE_W
);

  logic             start;
  logic             stop;
  logic             hold;
  logic             periodic;
  logic [CNT_W-1:0] cmp_val;
  logic [PRE_W-1:0] prescale;
  logic             irq_ack;
  logic             busy;
  logic             expired;
  logic             irq;
  logic [CNT_W-1:0] cnt_out;
`ifdef TIMER_OVF_CNT_EN
  logic [timer_pkg::OVF_W-1:0] ovf_cnt;
`endif

  modport master (
    output start, stop, hold, periodic, cmp_val, prescale, irq_ack,
    input  busy, expired, irq, cnt_out
`ifdef TIMER_OVF_CNT_EN
    , ovf_cnt
`endif
  );

  modport slave (
    input  start, stop, hold, periodic, cmp_val, prescale, irq_ack,
    output busy, expired, irq, cnt_out
`ifdef TIMER_OVF_CNT_EN
    , ovf_cnt
`endif
  );

endinterface

// File: rtl/tick_counter.sv
// ---------------------------------------------------------------------------
// tick_counter
//   CNT_W-bit up-counter datapath owned by interval_timer_ctrl.
//   clk, res_n : clock, asynchronous active-low reset
//   en_i       : count up by one
//   clr_i      : synchronous clear, wins over en_i
//   cnt_o      : current count
// ---------------------------------------------------------------------------
module tick_counter #(
  parameter int CNT_W = timer_pkg::DEF_CNT_W
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n)     cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i)  cnt_q <= cnt_q + 1'b1;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/interval_timer_ctrl.sv
// ---------------------------------------------------------------------------
// interval_timer_ctrl
//   Programmable interval timer controller. A prescaler produces ticks every
//   (prescale+1) clocks; each tick advances tick_counter until it equals the
//   latched compare value, at which point the counter is cleared, expired
//   pulses for one cycle and the sticky irq is set. One-shot runs return to
//   IDLE on the match, periodic runs keep going.
//   clk, res_n : clock, asynchronous active-low reset
//   bus        : interval_timer_ctrl_if.slave (control in, status out)
//   Optional macro: TIMER_OVF_CNT_EN adds a saturating missed-irq counter.
// ---------------------------------------------------------------------------
module interval_timer_ctrl
  import timer_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int PRE_W = DEF_PRE_W
) (
  input logic                  clk,
  input logic                  res_n,
  interval_timer_ctrl_if.slave bus
);

  state_e           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [PRE_W-1:0] pre_lat_q;
  logic [CNT_W-1:0] cmp_lat_q;
  logic             periodic_lat_q;
  logic             busy_q, expired_q, irq_q;
  logic [CNT_W-1:0] cnt;

  logic load, active, adv, tick, match;

  assign load   = (state_q == LOAD);
  assign active = (state_q == RUN) || (state_q == HOLD);
  // The timer only advances in a cycle with no stop/start/hold request, so a
  // restart discards any tick that would have landed on the same edge. HOLD
  // resumes counting in the very cycle hold drops, so the freeze lasts exactly
  // as many clocks as hold is high.
  assign adv    = active && !bus.stop && !bus.start && !bus.hold;
  assign tick   = adv && (pre_q == pre_lat_q);
  assign match  = tick && (cnt == cmp_lat_q);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    state_d = state_q;
    pre_d   = pre_q;

    if (bus.stop) begin
      state_d = IDLE;
    end else if (bus.start) begin
      state_d = LOAD;
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        LOAD: state_d = RUN;
        RUN, HOLD: begin
          if (bus.hold)                       state_d = HOLD;
          else if (match && !periodic_lat_q)  state_d = IDLE;
          else                                state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end

    if (load || bus.stop) pre_d = '0;
    else if (adv)         pre_d = tick ? '0 : pre_q + 1'b1;
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q        <= IDLE;
      pre_q          <= '0;
      pre_lat_q      <= '0;
      cmp_lat_q      <= '0;
      periodic_lat_q <= 1'b0;
      busy_q         <= 1'b0;
      expired_q      <= 1'b0;
      irq_q          <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      busy_q    <= (state_d != IDLE);
      expired_q <= match;
      if (load) begin
        pre_lat_q      <= bus.prescale;
        cmp_lat_q      <= bus.cmp_val;
        periodic_lat_q <= bus.periodic;
      end
      // A match in the same cycle as irq_ack keeps the interrupt asserted.
      if (match)            irq_q <= 1'b1;
      else if (bus.irq_ack) irq_q <= 1'b0;
    end
  end

  tick_counter #(.CNT_W(CNT_W)) u_tick_counter (
    .clk   (clk),
    .res_n (res_n),
    .en_i  (tick && !match),
    .clr_i (load || bus.stop || match),
    .cnt_o (cnt)
  );

`ifdef TIMER_OVF_CNT_EN
  logic [OVF_W-1:0] ovf_q;

  // Counts matches that land while the previous interrupt is still pending.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n)                                    ovf_q <= '0;
    else if (bus.irq_ack)                          ovf_q <= '0;
    else if (match && irq_q && (ovf_q != '1))      ovf_q <= ovf_q + 1'b1;
  end

  assign bus.ovf_cnt = ovf_q;
`endif

  assign bus.busy    = busy_q;
  assign bus.expired = expired_q;
  assign bus.irq     = irq_q;
  assign bus.cnt_out = cnt;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_interval_timer_ctrl
//   Self-checking bench for interval_timer_ctrl. Expected expiry cycles are
//   queued when a run is started and popped whenever expired is seen.
//   Optional macro: TIMER_OVF_CNT_EN enables the missed-irq counter scenario.
// ---------------------------------------------------------------------------
module tb_interval_timer_ctrl;

  logic clk = 1'b0;
  logic res_n;

  always #5 clk = ~clk;

  interval_timer_ctrl_if bus ();

  interval_timer_ctrl dut (
    .clk   (clk),
    .res_n (res_n),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;
  int exp_q[$];

  // Starts a run: start pulse with config, returns the cycle of RUN entry.
  task automatic do_start(input int cmp, input int pre, input int per, output int run0);
    bus.cmp_val  = 8'(cmp);
    bus.prescale = 4'(pre);
    bus.periodic = (per != 0);
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    @(negedge clk);
    run0 = cyc;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
  endtask

  task automatic test_reset();
    res_n = 1'b0;
    bus.start = 0; bus.stop = 0; bus.hold = 0; bus.periodic = 0;
    bus.cmp_val = '0; bus.prescale = '0; bus.irq_ack = 0;
    repeat (2) @(negedge clk);
    vectors++; if (bus.busy !== 1'b0)    begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    vectors++; if (bus.expired !== 1'b0) begin miscompares++; $display("FAIL reset_expired: got %b want 0", bus.expired); end
    vectors++; if (bus.irq !== 1'b0)     begin miscompares++; $display("FAIL reset_irq: got %b want 0", bus.irq); end
    vectors++; if (bus.cnt_out !== 8'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d want 0", bus.cnt_out); end
    res_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_oneshot();
    int r, e, seen;
    do_start(3, 1, 0, r);
    exp_q.push_back(r + 8);
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL oneshot_busy_run: got %b want 1", bus.busy); end
    vectors++; if (bus.irq !== 1'b0)  begin miscompares++; $display("FAIL oneshot_irq_pre: got %b want 0", bus.irq); end
    seen = 0;
    for (int k = 0; k < 20 && seen < 1; k++) begin
      @(negedge clk);
      if (bus.expired === 1'b1) begin
        seen++; vectors++;
        if (exp_q.size() == 0) begin miscompares++; $display("FAIL oneshot_expiry: unexpected at cycle %0d", cyc); end
        else begin e = exp_q.pop_front(); if (cyc !== e) begin miscompares++; $display("FAIL oneshot_expiry: got cycle %0d want %0d", cyc, e); end end
        vectors++; if (bus.irq !== 1'b1)     begin miscompares++; $display("FAIL oneshot_irq: got %b want 1", bus.irq); end
        vectors++; if (bus.busy !== 1'b0)    begin miscompares++; $display("FAIL oneshot_busy_after: got %b want 0", bus.busy); end
        vectors++; if (bus.cnt_out !== 8'd0) begin miscompares++; $display("FAIL oneshot_cnt: got %0d want 0", bus.cnt_out); end
      end
    end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL oneshot_timeout: %0d expiries missing", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_periodic();
    int r, e, seen;
    logic [7:0] want;
    do_start(2, 0, 1, r);
    for (int m = 1; m <= 10; m++) exp_q.push_back(r + 3 * m);
    vectors++; if (bus.cnt_out !== 8'd0) begin miscompares++; $display("FAIL periodic_cnt0: got %0d want 0", bus.cnt_out); end
    seen = 0;
    for (int k = 1; k <= 40 && seen < 10; k++) begin
      @(negedge clk);
      if (k <= 3) begin
        want = 8'(k % 3);
        vectors++; if (bus.cnt_out !== want) begin miscompares++; $display("FAIL periodic_cnt%0d: got %0d want %0d", k, bus.cnt_out, want); end
      end
      if (bus.expired === 1'b1) begin
        seen++; vectors++;
        if (exp_q.size() == 0) begin miscompares++; $display("FAIL periodic_expiry: unexpected at cycle %0d", cyc); end
        else begin e = exp_q.pop_front(); if (cyc !== e) begin miscompares++; $display("FAIL periodic_expiry: got cycle %0d want %0d", cyc, e); end end
      end
    end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL periodic_timeout: %0d expiries missing", exp_q.size()); exp_q.delete(); end
    pulse_stop();
  endtask

  task automatic test_hold();
    int r, e, seen;
    do_start(5, 0, 0, r);
    exp_q.push_back(r + 10);
    repeat (2) @(negedge clk);
    vectors++; if (bus.cnt_out !== 8'd2) begin miscompares++; $display("FAIL hold_cnt_entry: got %0d want 2", bus.cnt_out); end
    bus.hold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++; if (bus.cnt_out !== 8'd2) begin miscompares++; $display("FAIL hold_cnt_frozen%0d: got %0d want 2", k, bus.cnt_out); end
    end
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL hold_busy: got %b want 1", bus.busy); end
    bus.hold = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && seen < 1; k++) begin
      @(negedge clk);
      if (bus.expired === 1'b1) begin
        seen++; vectors++;
        if (exp_q.size() == 0) begin miscompares++; $display("FAIL hold_expiry: unexpected at cycle %0d", cyc); end
        else begin e = exp_q.pop_front(); if (cyc !== e) begin miscompares++; $display("FAIL hold_expiry: got cycle %0d want %0d", cyc, e); end end
      end
    end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL hold_timeout: %0d expiries missing", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_stop_restart();
    int r, e, seen;
    do_start(5, 0, 1, r);
    repeat (3) @(negedge clk);
    vectors++; if (bus.cnt_out !== 8'd3) begin miscompares++; $display("FAIL stop_cnt_pre: got %0d want 3", bus.cnt_out); end
    pulse_stop();
    vectors++; if (bus.busy !== 1'b0)    begin miscompares++; $display("FAIL stop_busy: got %b want 0", bus.busy); end
    vectors++; if (bus.cnt_out !== 8'd0) begin miscompares++; $display("FAIL stop_cnt: got %0d want 0", bus.cnt_out); end
    do_start(5, 0, 1, r);
    repeat (2) @(negedge clk);
    do_start(1, 0, 0, r);
    exp_q.push_back(r + 2);
    seen = 0;
    for (int k = 0; k < 20 && seen < 1; k++) begin
      @(negedge clk);
      if (bus.expired === 1'b1) begin
        seen++; vectors++;
        if (exp_q.size() == 0) begin miscompares++; $display("FAIL restart_expiry: unexpected at cycle %0d", cyc); end
        else begin e = exp_q.pop_front(); if (cyc !== e) begin miscompares++; $display("FAIL restart_expiry: got cycle %0d want %0d", cyc, e); end end
      end
    end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL restart_timeout: %0d expiries missing", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_irq_ack();
    int r, e;
    do_start(2, 0, 1, r);
    exp_q.push_back(r + 3);
    repeat (2) @(negedge clk);
    vectors++; if (bus.irq !== 1'b1) begin miscompares++; $display("FAIL ack_irq_pre: got %b want 1", bus.irq); end
    bus.irq_ack = 1'b1;
    @(negedge clk);
    bus.irq_ack = 1'b0;
    vectors++;
    if (bus.expired !== 1'b1) begin miscompares++; $display("FAIL ack_collide_expired: got %b want 1", bus.expired); end
    else begin e = exp_q.pop_front(); if (cyc !== e) begin miscompares++; $display("FAIL ack_collide_expiry: got cycle %0d want %0d", cyc, e); end end
    vectors++; if (bus.irq !== 1'b1) begin miscompares++; $display("FAIL ack_collide_irq: got %b want 1", bus.irq); end
    bus.irq_ack = 1'b1;
    @(negedge clk);
    bus.irq_ack = 1'b0;
    vectors++; if (bus.irq !== 1'b0) begin miscompares++; $display("FAIL ack_lone_irq: got %b want 0", bus.irq); end
    pulse_stop();
    exp_q.delete();
  endtask

  task automatic test_every_clock();
    int r, e;
    do_start(0, 0, 1, r);
    for (int k = 1; k <= 8; k++) exp_q.push_back(r + k);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      vectors++;
      if (bus.expired !== 1'b1) begin miscompares++; $display("FAIL every_clock_expired%0d: got %b want 1", k, bus.expired); end
      else begin e = exp_q.pop_front(); if (cyc !== e) begin miscompares++; $display("FAIL every_clock_expiry: got cycle %0d want %0d", cyc, e); end end
    end
    pulse_stop();
    vectors++; if (bus.expired !== 1'b0) begin miscompares++; $display("FAIL every_clock_stop: got %b want 0", bus.expired); end
    exp_q.delete();
  endtask

`ifdef TIMER_OVF_CNT_EN
  task automatic test_ovf();
    int r;
    bus.irq_ack = 1'b1;
    @(negedge clk);
    bus.irq_ack = 1'b0;
    vectors++; if (bus.ovf_cnt !== 8'd0) begin miscompares++; $display("FAIL ovf_clear0: got %0d want 0", bus.ovf_cnt); end
    do_start(0, 0, 1, r);
    repeat (2) @(negedge clk);
    vectors++; if (bus.ovf_cnt !== 8'd1) begin miscompares++; $display("FAIL ovf_first: got %0d want 1", bus.ovf_cnt); end
    repeat (298) @(negedge clk);
    vectors++; if (bus.ovf_cnt !== 8'd255) begin miscompares++; $display("FAIL ovf_sat: got %0d want 255", bus.ovf_cnt); end
    bus.irq_ack = 1'b1;
    @(negedge clk);
    bus.irq_ack = 1'b0;
    vectors++; if (bus.ovf_cnt !== 8'd0) begin miscompares++; $display("FAIL ovf_ack: got %0d want 0", bus.ovf_cnt); end
    pulse_stop();
  endtask
`endif

  task automatic test_async_reset();
    int r;
    do_start(5, 0, 1, r);
    repeat (3) @(negedge clk);
    #2 res_n = 1'b0;
    #1;
    vectors++; if (bus.busy !== 1'b0)    begin miscompares++; $display("FAIL async_busy: got %b want 0", bus.busy); end
    vectors++; if (bus.irq !== 1'b0)     begin miscompares++; $display("FAIL async_irq: got %b want 0", bus.irq); end
    vectors++; if (bus.expired !== 1'b0) begin miscompares++; $display("FAIL async_expired: got %b want 0", bus.expired); end
    vectors++; if (bus.cnt_out !== 8'd0) begin miscompares++; $display("FAIL async_cnt: got %0d want 0", bus.cnt_out); end
`ifdef TIMER_OVF_CNT_EN
    vectors++; if (bus.ovf_cnt !== 8'd0) begin miscompares++; $display("FAIL async_ovf: got %0d want 0", bus.ovf_cnt); end
`endif
    @(negedge clk);
    res_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_hold();
    test_stop_restart();
    test_irq_ack();
    test_every_clock();
`ifdef TIMER_OVF_CNT_EN
    test_ovf();
`endif
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
